// File: rtl/alu_operand_stage_pkg.sv
// alu_operand_stage_pkg
// Shared definitions for the operand-fetch stage that feeds the ALU.
// Holds the word/register-address/opcode widths, the opcode constants
// shared with the ALU, the output-slot state encoding and a small helper
// that turns a register address into a one-hot pending-bit mask.
package alu_operand_stage_pkg;

   localparam int WIDTH = 16;
   localparam int NREG  = 16;
   localparam int AW    = 4;
   localparam int OPW   = 5;

   typedef logic [WIDTH-1:0] word_t;
   typedef logic [AW-1:0]    regaddr_t;
   typedef logic [OPW-1:0]   aluop_t;

   localparam aluop_t OP_ADD  = 5'd0;
   localparam aluop_t OP_SUB  = 5'd1;
   localparam aluop_t OP_AND  = 5'd2;
   localparam aluop_t OP_OR   = 5'd3;
   localparam aluop_t OP_XOR  = 5'd4;
   localparam aluop_t OP_SHL  = 5'd5;
   localparam aluop_t OP_SHR  = 5'd6;
   localparam aluop_t OP_PASS = 5'd7;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_e;

   // One-hot mask for a register; r0 maps to an empty mask so it can never
   // become pending or be cleared.
   function automatic logic [NREG-1:0] regMask(input regaddr_t addr);
      logic [NREG-1:0] mask;
      mask = '0;
      if (addr != '0) mask[addr] = 1'b1;
      return mask;
   endfunction

endpackage

// File: rtl/alu_operand_stage_regfile_2r1w.sv
// regfile_2r1w
// 16-entry register file with two combinational read ports and one write
// port. A read of the register being written this cycle returns the write
// data. r0 always reads zero and ignores writes.
// Ports:
//   clk_i            clock, rising edge
//   reset_i          synchronous active-high reset, clears r1..r15
//   we_i/waddr_i/wdata_i   write port
//   raddrA_i/rdataA_o      read port A
//   raddrB_i/rdataB_o      read port B
module regfile_2r1w
   import alu_operand_stage_pkg::*;
(
   input  logic     clk_i,
   input  logic     reset_i,
   input  logic     we_i,
   input  regaddr_t waddr_i,
   input  word_t    wdata_i,
   input  regaddr_t raddrA_i,
   output word_t    rdataA_o,
   input  regaddr_t raddrB_i,
   output word_t    rdataB_o
);

   word_t regs_q [NREG];

   logic writeLive;

   // A write to r0 is discarded; writes are also dropped in a reset cycle.
   assign writeLive = we_i && (waddr_i != '0);

   // Storage update; reset wins over a same-cycle write.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (writeLive) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   // Read ports with write-through bypass so a dependent instruction can be
   // accepted in the same cycle its source is written back.
   always_comb begin
      rdataA_o = regs_q[raddrA_i];
      if (raddrA_i == '0)                           rdataA_o = '0;
      else if (writeLive && (waddr_i == raddrA_i))  rdataA_o = wdata_i;

      rdataB_o = regs_q[raddrB_i];
      if (raddrB_i == '0)                           rdataB_o = '0;
      else if (writeLive && (waddr_i == raddrB_i))  rdataB_o = wdata_i;
   end

endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage
// Operand-fetch stage directly upstream of the ALU. Accepts decoded
// instructions over valid/ready, reads (with writeback bypass) the source
// operands, stalls on pending-write hazards via a scoreboard, and holds the
// operands in an output register presented to the ALU.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   in_valid/in_ready                 instruction handshake (ready is comb.)
//   in_op, in_rd, in_rs, in_rt        opcode, destination, sources
//   in_imm, in_useimm                 immediate replaces rt for Y when set
//   out_valid/out_ready               operand handshake to the ALU
//   X, Y, ALUop, out_rd               registered operands, opcode, dest
//   wb_en, wb_rd, wb_data             ALU result writeback
module alu_operand_stage
   import alu_operand_stage_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  logic     in_valid,
   output logic     in_ready,
   input  aluop_t   in_op,
   input  regaddr_t in_rd,
   input  regaddr_t in_rs,
   input  regaddr_t in_rt,
   input  word_t    in_imm,
   input  logic     in_useimm,
   output logic     out_valid,
   input  logic     out_ready,
   output word_t    X,
   output word_t    Y,
   output aluop_t   ALUop,
   output regaddr_t out_rd,
   input  logic     wb_en,
   input  regaddr_t wb_rd,
   input  word_t    wb_data
);

   slot_e           slot_q, slot_d;
   logic [NREG-1:0] pending_q, pending_d;
   word_t           x_q, x_d, y_q, y_d;
   aluop_t          op_q, op_d;
   regaddr_t        rd_q, rd_d;

   word_t           rsValue, rtValue;
   logic [NREG-1:0] livePending;
   logic            hazard;
   logic            accept;

   regfile_2r1w u_regfile (
      .clk_i    (clk),
      .reset_i  (reset),
      .we_i     (wb_en),
      .waddr_i  (wb_rd),
      .wdata_i  (wb_data),
      .raddrA_i (in_rs),
      .rdataA_o (rsValue),
      .raddrB_i (in_rt),
      .rdataB_o (rtValue)
   );

   assign out_valid = (slot_q == SLOT_FULL);
   assign X         = x_q;
   assign Y         = y_q;
   assign ALUop     = op_q;
   assign out_rd    = rd_q;

   // Hazard detection against the scoreboard. A bit being cleared by this
   // cycle's writeback no longer blocks, since the read path forwards it.
   // rd is checked as well so two writes to one register stay ordered.
   always_comb begin
      livePending = pending_q & ~(wb_en ? regMask(wb_rd) : '0);
      hazard      = livePending[in_rs]
                  | (!in_useimm && livePending[in_rt])
                  | livePending[in_rd];
      in_ready    = !reset && (!out_valid || out_ready) && !hazard;
      accept      = in_valid && in_ready;
      // Setting after clearing lets a new claim win over a same-cycle release.
      pending_d   = livePending | (accept ? regMask(in_rd) : '0);
   end

   // Output slot next state and operand register load.
   always_comb begin
      slot_d = slot_q;
      x_d    = x_q;
      y_d    = y_q;
      op_d   = op_q;
      rd_d   = rd_q;
      case (slot_q)
         SLOT_EMPTY: if (accept) slot_d = SLOT_FULL;
         SLOT_FULL:  if (out_ready && !accept) slot_d = SLOT_EMPTY;
         default:    slot_d = SLOT_EMPTY;
      endcase
      if (accept) begin
         x_d  = rsValue;
         y_d  = in_useimm ? in_imm : rtValue;
         op_d = in_op;
         rd_d = in_rd;
      end
   end

   // State registers; reset drops the in-flight instruction and scoreboard.
   always_ff @(posedge clk) begin
      if (reset) begin
         slot_q    <= SLOT_EMPTY;
         pending_q <= '0;
         x_q       <= '0;
         y_q       <= '0;
         op_q      <= '0;
         rd_q      <= '0;
      end else begin
         slot_q    <= slot_d;
         pending_q <= pending_d;
         x_q       <= x_d;
         y_q       <= y_d;
         op_q      <= op_d;
         rd_q      <= rd_d;
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage
// Directed scenarios followed by random traffic, checked cycle by cycle
// against a register-array/pending-list model of the operand stage.
module tb_alu_operand_stage;
   import alu_operand_stage_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_op;
   logic [3:0]  in_rd, in_rs, in_rt;
   logic [15:0] in_imm;
   logic        in_useimm;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] X, Y;
   logic [4:0]  ALUop;
   logic [3:0]  out_rd;
   logic        wb_en;
   logic [3:0]  wb_rd;
   logic [15:0] wb_data;

   int assertCount = 0;
   int failCount   = 0;

   logic [15:0] mRegs [16];
   bit          mPend [16];
   bit          mValid;
   logic [15:0] mX, mY;
   logic [4:0]  mOp;
   logic [3:0]  mRd;
   bit          lastReady;

   logic [15:0] heldX, heldY;
   logic [4:0]  heldOp;

   alu_operand_stage dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_rd     (in_rd),
      .in_rs     (in_rs),
      .in_rt     (in_rt),
      .in_imm    (in_imm),
      .in_useimm (in_useimm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .X         (X),
      .Y         (Y),
      .ALUop     (ALUop),
      .out_rd    (out_rd),
      .wb_en     (wb_en),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Model view of a source read: r0 is zero, a same-cycle writeback is seen.
   function automatic logic [15:0] modelRead(input logic [3:0] a);
      if (a == 4'd0) return 16'h0000;
      if (wb_en && (wb_rd == a)) return wb_data;
      return mRegs[a];
   endfunction

   // A register blocks when it has an outstanding write not retiring now.
   function automatic bit modelBusy(input logic [3:0] a);
      return (a != 4'd0) && mPend[a] && !(wb_en && (wb_rd == a));
   endfunction

   function automatic bit modelReady();
      if (reset) return 1'b0;
      if (mValid && !out_ready) return 1'b0;
      if (modelBusy(in_rs)) return 1'b0;
      if (!in_useimm && modelBusy(in_rt)) return 1'b0;
      if (modelBusy(in_rd)) return 1'b0;
      return 1'b1;
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit rst, input bit iv, input logic [4:0] op,
                                input logic [3:0] rd, input logic [3:0] rs,
                                input logic [3:0] rt, input logic [15:0] imm,
                                input bit ui, input bit ordy, input bit wbe,
                                input logic [3:0] wbrd, input logic [15:0] wbd);
      reset     = rst;
      in_valid  = iv;
      in_op     = op;
      in_rd     = rd;
      in_rs     = rs;
      in_rt     = rt;
      in_imm    = imm;
      in_useimm = ui;
      out_ready = ordy;
      wb_en     = wbe;
      wb_rd     = wbrd;
      wb_data   = wbd;
   endtask

   // One clock: drive, check the combinational ready, clock, update the
   // model and compare the registered outputs.
   task automatic doCycle(input bit rst, input bit iv, input logic [4:0] op,
                          input logic [3:0] rd, input logic [3:0] rs,
                          input logic [3:0] rt, input logic [15:0] imm,
                          input bit ui, input bit ordy, input bit wbe,
                          input logic [3:0] wbrd, input logic [15:0] wbd);
      bit          expReady;
      logic [15:0] expX, expY;
      applyStimulus(rst, iv, op, rd, rs, rt, imm, ui, ordy, wbe, wbrd, wbd);
      #1;
      expReady  = modelReady();
      expX      = modelRead(rs);
      expY      = ui ? imm : modelRead(rt);
      lastReady = in_ready;
      checkOutput("in_ready", 16'(in_ready), 16'(expReady));
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            mRegs[i] = 16'h0000;
            mPend[i] = 1'b0;
         end
         mValid = 1'b0;
         mX = 16'h0000; mY = 16'h0000; mOp = 5'd0; mRd = 4'd0;
      end else begin
         if (wbe && (wbrd != 4'd0)) begin
            mRegs[wbrd] = wbd;
            mPend[wbrd] = 1'b0;
         end
         if (iv && expReady) begin
            mX = expX; mY = expY; mOp = op; mRd = rd;
            mValid = 1'b1;
            if (rd != 4'd0) mPend[rd] = 1'b1;
         end else if (ordy) begin
            mValid = 1'b0;
         end
      end
      #1;
      checkOutput("out_valid", 16'(out_valid), 16'(mValid));
      checkOutput("X", X, mX);
      checkOutput("Y", Y, mY);
      checkOutput("ALUop", 16'(ALUop), 16'(mOp));
      checkOutput("out_rd", 16'(out_rd), 16'(mRd));
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         mRegs[i] = 16'h0000;
         mPend[i] = 1'b0;
      end
      mValid = 1'b0;
      mX = 16'h0000; mY = 16'h0000; mOp = 5'd0; mRd = 4'd0;
      lastReady = 1'b0;

      // Reset
      doCycle(1, 0, OP_ADD, 0, 0, 0, 16'h0, 0, 1, 0, 0, 16'h0);
      doCycle(1, 0, OP_ADD, 0, 0, 0, 16'h0, 0, 1, 0, 0, 16'h0);
      checkOutput("reset_out_valid", 16'(out_valid), 16'h0);
      checkOutput("reset_X", X, 16'h0);

      // ADD r1 <- r0, r0
      doCycle(0, 1, OP_ADD, 1, 0, 0, 16'h0, 0, 1, 0, 0, 16'h0);
      checkOutput("first_valid", 16'(out_valid), 16'h1);
      checkOutput("first_rd", 16'(out_rd), 16'h1);
      checkOutput("first_XY", X | Y, 16'h0);

      // Reader of r1 stalls until r1 is written back, then forwards
      doCycle(0, 1, OP_SUB, 4, 1, 0, 16'h0, 0, 1, 0, 0, 16'h0);
      checkOutput("raw_stall", 16'(lastReady), 16'h0);
      doCycle(0, 1, OP_SUB, 4, 1, 0, 16'h0, 0, 1, 1, 1, 16'h0055);
      checkOutput("raw_release", 16'(lastReady), 16'h1);
      checkOutput("raw_fwd_X", X, 16'h0055);

      // r2 = 0x1234, retire r4, then immediate form
      doCycle(0, 0, OP_ADD, 0, 0, 0, 16'h0, 0, 1, 1, 2, 16'h1234);
      doCycle(0, 0, OP_ADD, 0, 0, 0, 16'h0, 0, 1, 1, 4, 16'h0000);
      doCycle(0, 1, OP_OR, 0, 2, 0, 16'h00FF, 1, 1, 0, 0, 16'h0);
      checkOutput("imm_X", X, 16'h1234);
      checkOutput("imm_Y", Y, 16'h00FF);

      // r3 pending, writeback and dependent accept in the same cycle
      doCycle(0, 1, OP_ADD, 3, 0, 0, 16'h0, 1, 1, 0, 0, 16'h0);
      doCycle(0, 1, OP_AND, 0, 3, 0, 16'h0001, 1, 1, 1, 3, 16'hBEEF);
      checkOutput("wb_same_cycle_ready", 16'(lastReady), 16'h1);
      checkOutput("wb_same_cycle_X", X, 16'hBEEF);
      doCycle(0, 1, OP_XOR, 0, 3, 3, 16'h0, 0, 1, 0, 0, 16'h0);
      checkOutput("r3_cleared_ready", 16'(lastReady), 16'h1);
      checkOutput("r3_cleared_Y", Y, 16'hBEEF);

      // Back-pressure: hold three cycles, then release
      doCycle(0, 1, OP_SHL, 6, 2, 3, 16'h0, 0, 1, 0, 0, 16'h0);
      heldX = X; heldY = Y; heldOp = ALUop;
      for (int i = 0; i < 3; i++) begin
         doCycle(0, 1, OP_PASS, 7, 1, 1, 16'h0, 0, 0, 0, 0, 16'h0);
         checkOutput("hold_ready", 16'(lastReady), 16'h0);
         checkOutput("hold_X", X, heldX);
         checkOutput("hold_Y", Y, heldY);
         checkOutput("hold_op", 16'(ALUop), 16'(heldOp));
      end
      doCycle(0, 1, OP_PASS, 7, 1, 1, 16'h0, 0, 1, 0, 0, 16'h0);
      checkOutput("release_ready", 16'(lastReady), 16'h1);
      checkOutput("release_X", X, 16'h0055);
      checkOutput("release_op", 16'(ALUop), 16'(OP_PASS));

      // r0 stays zero and never stalls
      doCycle(0, 0, OP_ADD, 0, 0, 0, 16'h0, 0, 1, 1, 0, 16'hFFFF);
      doCycle(0, 1, OP_ADD, 0, 0, 0, 16'h0, 0, 1, 0, 0, 16'h0);
      checkOutput("r0_X", X, 16'h0);
      doCycle(0, 1, OP_SUB, 0, 0, 0, 16'h0, 0, 1, 0, 0, 16'h0);
      checkOutput("rd0_no_stall", 16'(lastReady), 16'h1);

      // Reset while busy with r5 pending and a writeback in the reset cycle
      doCycle(0, 1, OP_ADD, 5, 0, 0, 16'h0, 1, 1, 0, 0, 16'h0);
      doCycle(0, 0, OP_ADD, 0, 0, 0, 16'h0, 0, 0, 0, 0, 16'h0);
      checkOutput("pre_reset_valid", 16'(out_valid), 16'h1);
      doCycle(1, 1, OP_ADD, 0, 5, 0, 16'h0, 1, 0, 1, 2, 16'h7777);
      checkOutput("reset_cycle_ready", 16'(lastReady), 16'h0);
      checkOutput("mid_reset_valid", 16'(out_valid), 16'h0);
      doCycle(0, 1, OP_ADD, 0, 5, 0, 16'h0, 1, 1, 0, 0, 16'h0);
      checkOutput("post_reset_r5_ready", 16'(lastReady), 16'h1);
      checkOutput("post_reset_r5_X", X, 16'h0);
      doCycle(0, 1, OP_ADD, 0, 2, 0, 16'h0, 1, 1, 0, 0, 16'h0);
      checkOutput("reset_wb_ignored", X, 16'h0);

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         bit          rRst, rIv, rUi, rOrdy, rWbe;
         logic [3:0]  rRd, rRs, rRt, rWbRd;
         rRst  = ($urandom_range(0, 63) == 0);
         rIv   = ($urandom_range(0, 3) != 0);
         rUi   = $urandom_range(0, 1) == 1;
         rOrdy = ($urandom_range(0, 3) != 0);
         rWbe  = ($urandom_range(0, 9) < 4);
         rRd   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
         rRs   = 4'($urandom);
         rRt   = 4'($urandom);
         rWbRd = 4'($urandom);
         doCycle(rRst, rIv, 5'($urandom_range(0, 7)), rRd, rRs, rRt,
                 16'($urandom), rUi, rOrdy, rWbe, rWbRd, 16'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               assertCount, failCount);
      $finish;
   end

endmodule
